// File: rtl/alu_exec_ctrl_pkg.sv
// rtl/alu_exec_ctrl_pkg.sv - shared widths, opcode encodings and FSM states
package alu_exec_ctrl_pkg;

  localparam int OPSIZE     = 4;
  localparam int ALUWIDTH   = 8;
  localparam int REGADDR    = 3;
  localparam int NREGS      = 2 ** REGADDR;
  localparam int INSTRWIDTH = OPSIZE + 3 * REGADDR;

  localparam logic [OPSIZE-1:0] OP_ADD = 4'd0;
  localparam logic [OPSIZE-1:0] OP_SUB = 4'd1;
  localparam logic [OPSIZE-1:0] OP_AND = 4'd2;
  localparam logic [OPSIZE-1:0] OP_OR  = 4'd3;
  localparam logic [OPSIZE-1:0] OP_LS  = 4'd4;
  localparam logic [OPSIZE-1:0] OP_RS  = 4'd5;
  localparam logic [OPSIZE-1:0] OP_LDI = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
  } state_e;

  function automatic logic op_legal(input logic [OPSIZE-1:0] op);
    return op <= OP_LDI;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_regfile8.sv
// rtl/alu_exec_ctrl_regfile8.sv - 8-entry register file, r0 hardwired to zero
import alu_exec_ctrl_pkg::*;

module regfile8 (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [REGADDR-1:0]  rs1_addr_i,
  input  logic [REGADDR-1:0]  rs2_addr_i,
  input  logic [REGADDR-1:0]  dbg_addr_i,
  input  logic                wr_en_i,
  input  logic [REGADDR-1:0]  wr_addr_i,
  input  logic [ALUWIDTH-1:0] wr_data_i,
  output logic [ALUWIDTH-1:0] rs1_data_o,
  output logic [ALUWIDTH-1:0] rs2_data_o,
  output logic [ALUWIDTH-1:0] dbg_data_o
);

  logic [ALUWIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en_i && wr_addr_i != '0) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage sequencer feeding an external combinational ALU
import alu_exec_ctrl_pkg::*;

module alu_exec_ctrl (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  instr_valid_i,
  input  logic [INSTRWIDTH-1:0] instr_i,
  output logic                  instr_ready_o,
  output logic [OPSIZE-1:0]     alu_opcode_o,
  output logic [ALUWIDTH-1:0]   alu_in1_o,
  output logic [ALUWIDTH-1:0]   alu_in2_o,
  input  logic [ALUWIDTH-1:0]   alu_out_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ALUWIDTH-1:0]   result_o,
  input  logic [REGADDR-1:0]    dbg_addr_i,
  output logic [ALUWIDTH-1:0]   dbg_data_o
);

  state_e                  state_q, state_d;
  logic [INSTRWIDTH-1:0]   instr_q, instr_d;
  logic [OPSIZE-1:0]       opcode_q, opcode_d;
  logic [ALUWIDTH-1:0]     in1_q, in1_d, in2_q, in2_d;
  logic [ALUWIDTH-1:0]     cap_q, cap_d, result_q, result_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    wr_en;
  logic [ALUWIDTH-1:0]     rs1_data, rs2_data;

  logic [OPSIZE-1:0]  f_op;
  logic [REGADDR-1:0] f_rd, f_rs1, f_rs2;
  assign {f_op, f_rd, f_rs1, f_rs2} = instr_q;

  regfile8 u_regfile (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rs1_addr_i (f_rs1),
    .rs2_addr_i (f_rs2),
    .dbg_addr_i (dbg_addr_i),
    .wr_en_i    (wr_en),
    .wr_addr_i  (f_rd),
    .wr_data_i  (cap_q),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .dbg_data_o (dbg_data_o)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    opcode_d = opcode_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    cap_d    = cap_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid_i) begin
          instr_d = instr_i;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // LDI rides through the ALU as imm | 0 so writeback has a single source
        if (f_op == OP_LDI) begin
          opcode_d = OP_OR;
          in1_d    = ALUWIDTH'({f_rs1, f_rs2});
          in2_d    = '0;
        end else begin
          opcode_d = f_op;
          in1_d    = rs1_data;
          in2_d    = rs2_data;
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cap_d   = alu_out_i;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (op_legal(f_op)) begin
          wr_en    = 1'b1;
          result_d = cap_q;
          done_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      opcode_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      cap_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      opcode_q <= opcode_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      cap_q    <= cap_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign instr_ready_o = (state_q == ST_IDLE);
  assign alu_opcode_o  = opcode_q;
  assign alu_in1_o     = in1_q;
  assign alu_in2_o     = in2_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign result_o      = result_q;

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage controller that sits directly upstream of the ALU and feeds it. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 8-entry register file. It drives the ALU's opcode and operand inputs from registers, then captures the ALU result and writes it back to the destination register. The ALU stays purely combinational; all sequencing, storage and writeback live here.

## Interface
Parameters (from shared `parameters.v`):
- `opsize`, 4: opcode width, shared with the ALU.
- `aluwidth`, 8: datapath width, shared with the ALU.
- `regaddr`, 3: register address width (8 registers).
- `instrwidth`, `opsize+3*regaddr` (13): instruction word width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  `instrwidth`  instruction fields, MSB first: `{op, rd, rs1, rs2}`.
- `instr_ready`  out  1  high only in IDLE.
- `alu_opcode`  out  `opsize`  registered opcode to the ALU.
- `alu_in1`  out  `aluwidth`  registered operand A to the ALU.
- `alu_in2`  out  `aluwidth`  registered operand B to the ALU.
- `alu_out`  in  `aluwidth`  combinational ALU result.
- `done`  out  1  one-cycle pulse when writeback completes.
- `err`  out  1  one-cycle pulse when an illegal opcode retires.
- `result`  out  `aluwidth`  value written back (held until the next `done`).
- `dbg_addr`  in  `regaddr`  debug read address.
- `dbg_data`  out  `aluwidth`  combinational read of `regs[dbg_addr]`.

## Operation
- Opcode encodings: ADD=0, SUB=1, AND=2, OR=3, LS=4, RS=5, LDI=6. Values 7–15 are illegal.
- r0 reads as 0. Writes to r0 are discarded, but `done` and `result` behave normally.
- LDI: the immediate is `{rs1, rs2}`, 6 bits, zero-extended. LDI bypasses the ALU computation: the block drives `alu_opcode`=OR, `alu_in1`=imm and `alu_in2`=0, so the ALU returns the immediate.
- FSM states: IDLE → READ → EXEC → WB → IDLE.
  - IDLE: `instr_ready`=1. Handshake fires when `instr_valid & instr_ready`. On handshake, latch `instr` and go to READ.
  - READ: load `alu_opcode`, `alu_in1`=`regs[rs1]` and `alu_in2`=`regs[rs2]`, or the LDI mapping above. Go to EXEC.
  - EXEC: ALU inputs are stable. Capture `alu_out` into the result register. Go to WB.
  - WB: if the opcode is legal, write `regs[rd]`, update `result` and pulse `done`. If illegal, make no write, leave `result` unchanged and pulse `err`. Go to IDLE.
- Arithmetic follows the ALU: modulo 2^`aluwidth`, with no carry or borrow flag. Shifts by ≥`aluwidth` yield 0.
- `instr` is ignored outside IDLE. A valid held while ready is low is not consumed.

## Timing
- Handshake on edge N. `done`/`err` is high during the cycle after edge N+3, and the register write is visible on `dbg_data` in that same cycle.
- Throughput: one instruction per 4 cycles. The next handshake is possible on edge N+4.
- `alu_*` outputs change only on the READ edge and are held through EXEC and WB.
- Reset, taking effect on the edge where `reset`=1, regardless of state:
  - state=IDLE
  - all registers, `alu_opcode`, `alu_in1`, `alu_in2` and `result` cleared to 0
  - `done`=`err`=0
  - `instr_ready` high from the cycle after reset deasserts
  - an in-flight instruction is dropped with no writeback.
- Read-after-write needs no forwarding: WB completes before the next READ.

## Structure
- The shared `parameters.v` holds the opcode macros (including the new LDI), `opsize`, `aluwidth`, `regaddr` and `instrwidth`.
- One sub-module, `regfile8`: 8×`aluwidth` storage with two combinational read ports plus a debug port, one synchronous write port, r0 forced to 0, and synchronous clear on `reset`.
- The FSM and operand registers live in `alu_exec_ctrl`. The ALU is instantiated beside it at the top level, not inside it.

## Test plan
- LDI r1,5 then LDI r2,3 → `done` at N+3 each; `dbg_data`(r1)=5 and (r2)=3.
- ADD r3,r1,r2 → `alu_opcode`=0, `alu_in1`=5, `alu_in2`=3 during EXEC; `result`=8; r3=8.
- SUB r4,r2,r1 → `result`=8'hFE (wrap). LS r5,r1,r2 → 40. RS r6,r5,r2 → 5.
- ADD r0,r1,r2 → `done` pulses, `result`=8, r0 still reads 0. Opcode 7 → `err` pulse, no `done`, no register changes.
- `instr_valid` held high continuously → exactly one acceptance per 4 cycles; `instr_ready` low in READ, EXEC and WB.
- `reset` asserted in EXEC of ADD r3 → no writeback, all registers 0, and the next LDI is accepted the cycle after reset drops.
